// File: rtl/ifq.sv
// rtl/ifq.sv - instruction fetch queue: circular {pc, instr} FIFO with fetch hold, overflow flag and jump flush
module ifq #(
  parameter int DEPTH       = 4,
  parameter int HOLD_MARGIN = 2,
  parameter int FLUSH_DROP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_instr_i,
  output logic        in_ready_o,
  output logic        hold_o,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] HOLD_TH = CW'(DEPTH - HOLD_MARGIN);
  localparam logic [1:0]    DROP_C  = 2'(FLUSH_DROP);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    drop_cnt;
  logic          overflow;
  logic          push;
  logic          pop;
  logic          drop;
  logic [63:0]   head;

  // Inside the drop window every beat is taken so the stale SRAM data can be swallowed.
  assign in_ready_o  = (count != FULL_C) || (drop_cnt != 2'd0);
  assign out_valid_o = (count != '0);
  assign hold_o      = (count >= HOLD_TH);
  assign count_o     = count;
  assign overflow_o  = overflow;

  assign push = in_valid_i && in_ready_o && (drop_cnt == 2'd0) && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;
  assign drop = in_valid_i && (drop_cnt != 2'd0) && !flush_i;

  assign head        = mem[rd_ptr];
  assign out_pc_o    = out_valid_o ? head[63:32] : 32'd0;
  assign out_instr_o = out_valid_o ? head[31:0]  : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= 2'd0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 64'd0;
      end
    end else if (flush_i) begin
      // Storage is left as is; only the bookkeeping restarts.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= DROP_C;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_pc_i, in_instr_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (in_valid_i && !in_ready_o) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifq.sv
// tb/tb_ifq.sv - table-driven and scoreboard bench for ifq
module tb_ifq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic [31:0] in_pc_i;
  logic [31:0] in_instr_i;
  logic        in_ready_o;
  logic        hold_o;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  ifq #(.DEPTH(4), .HOLD_MARGIN(2), .FLUSH_DROP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
    .in_ready_o(in_ready_o), .hold_o(hold_o), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        fl;
    logic        acc;
    logic [2:0]  cnt;
    logic        rdy;
    logic        hold;
    logic        ovf;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle; head and pop data are checked against the scoreboard before the edge.
  task automatic cycle(input string nm, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input logic acc);
    @(negedge clk);
    in_valid_i  = v;
    in_pc_i     = pc;
    in_instr_i  = ins;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    chk({nm, " valid"}, 32'(out_valid_o), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      chk({nm, " head_pc"}, out_pc_o, sb_q[0][63:32]);
      chk({nm, " head_instr"}, out_instr_o, sb_q[0][31:0]);
    end else begin
      chk({nm, " idle_pc"}, out_pc_o, 32'd0);
      chk({nm, " idle_instr"}, out_instr_o, 32'd0);
    end
    if (fl) sb_q.delete();
    else if (ordy && sb_q.size() != 0) void'(sb_q.pop_front());
    if (acc) sb_q.push_back({pc, ins});
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic post(input string nm, input logic [2:0] cnt, input logic rdy, input logic hold, input logic ovf);
    chk({nm, " count"}, 32'(count_o), 32'(cnt));
    chk({nm, " ready"}, 32'(in_ready_o), 32'(rdy));
    chk({nm, " hold"}, 32'(hold_o), 32'(hold));
    chk({nm, " overflow"}, 32'(overflow_o), 32'(ovf));
  endtask

  initial begin
    // fill, overflow, drain
    tbl[0]  = '{1'b1, 32'h00, 32'h013, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h04, 32'h093, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h08, 32'h113, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h0C, 32'h193, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'h10, 32'h213, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 32'h14, 32'h293, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 32'h00, 32'h000, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 32'h00, 32'h000, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'h00, 32'h000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h00, 32'h000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    // concurrent push/pop
    tbl[10] = '{1'b1, 32'h20, 32'h00100093, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 32'h24, 32'h00200113, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 32'h28, 32'h00300193, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 32'h2C, 32'h00400213, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 32'h00, 32'h000, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 32'h00, 32'h000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid_i = 1'b0; in_pc_i = '0; in_instr_i = '0;
    out_ready_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    post("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    chk("reset valid", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cycle($sformatf("row%0d", i), tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].ordy, tbl[i].fl, tbl[i].acc);
      post($sformatf("row%0d", i), tbl[i].cnt, tbl[i].rdy, tbl[i].hold, tbl[i].ovf);
    end

    // flush with a beat in the same cycle, then one stale beat dropped
    cycle("f_fill0", 1'b1, 32'h50, 32'hA5A50050, 1'b0, 1'b0, 1'b1);
    cycle("f_fill1", 1'b1, 32'h54, 32'hA5A50054, 1'b0, 1'b0, 1'b1);
    cycle("f_fill2", 1'b1, 32'h58, 32'hA5A50058, 1'b0, 1'b0, 1'b1);
    post("f_fill2", 3'd3, 1'b1, 1'b1, 1'b1);
    cycle("f_flush", 1'b1, 32'h10, 32'hA5A50010, 1'b1, 1'b1, 1'b0);
    post("f_flush", 3'd0, 1'b1, 1'b0, 1'b1);
    cycle("f_drop", 1'b1, 32'h14, 32'hA5A50014, 1'b0, 1'b0, 1'b0);
    post("f_drop", 3'd0, 1'b1, 1'b0, 1'b1);
    cycle("f_acc", 1'b1, 32'h40, 32'hA5A50040, 1'b0, 1'b0, 1'b1);
    post("f_acc", 3'd1, 1'b1, 1'b0, 1'b1);
    cycle("f_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    post("f_drain", 3'd0, 1'b1, 1'b0, 1'b1);

    // second flush inside the drop window; idle cycle must not consume the window
    cycle("w_fill", 1'b1, 32'h60, 32'hA5A50060, 1'b0, 1'b0, 1'b1);
    cycle("w_flush1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("w_flush2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("w_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    post("w_idle", 3'd0, 1'b1, 1'b0, 1'b1);
    cycle("w_drop", 1'b1, 32'h64, 32'hA5A50064, 1'b0, 1'b0, 1'b0);
    post("w_drop", 3'd0, 1'b1, 1'b0, 1'b1);
    cycle("w_acc", 1'b1, 32'h68, 32'hA5A50068, 1'b0, 1'b0, 1'b1);
    post("w_acc", 3'd1, 1'b1, 1'b0, 1'b1);
    cycle("w_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    post("w_drain", 3'd0, 1'b1, 1'b0, 1'b1);

    // asynchronous reset mid-stream with three entries queued
    cycle("r_fill0", 1'b1, 32'h80, 32'hA5A50080, 1'b0, 1'b0, 1'b1);
    cycle("r_fill1", 1'b1, 32'h84, 32'hA5A50084, 1'b0, 1'b0, 1'b1);
    cycle("r_fill2", 1'b1, 32'h88, 32'hA5A50088, 1'b0, 1'b0, 1'b1);
    post("r_fill2", 3'd3, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    post("r_async", 3'd0, 1'b1, 1'b0, 1'b0);
    chk("r_async valid", 32'(out_valid_o), 32'd0);
    chk("r_async pc", out_pc_o, 32'd0);
    chk("r_async instr", out_instr_o, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("r_idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    post("r_idle", 3'd0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifq.md
# ifq

Instruction fetch queue between the instruction SRAM/fetch stage and the decode/execute stage. It buffers `{pc, instr}` pairs in a small circular FIFO with a valid/ready handshake. It tells fetch to stall before the queue overflows. On a taken jump it flushes its contents and discards the stale fetch beats still in flight behind the flush.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `HOLD_MARGIN`, 2: `hold_o` asserts when the occupancy is ≥ DEPTH−HOLD_MARGIN; range 1..DEPTH.
- `FLUSH_DROP`, 1: number of `in_valid_i` beats discarded after a flush, covering the SRAM read latency; range 0..3.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid_i`  in  1  fetched instruction present, from SRAM/fetch.
- `in_pc_i`  in  32  PC of the fetched instruction.
- `in_instr_i`  in  32  fetched instruction word.
- `in_ready_o`  out  1  queue can take a beat.
- `hold_o`  out  1  stall request to fetch; fetch stops advancing its PC.
- `flush_i`  in  1  jump taken, from execute; same cycle as the jump redirect.
- `out_valid_o`  out  1  head entry is valid.
- `out_ready_i`  in  1  consumer takes the head entry.
- `out_pc_o`  out  32  PC of the head entry.
- `out_instr_o`  out  32  instruction of the head entry.
- `count_o`  out  clog2(DEPTH)+1  occupancy.
- `overflow_o`  out  1  sticky; set when a beat arrived while the queue was full.

## Operation
State:
- Storage array, DEPTH×64 bits.
- `wr_ptr`, `rd_ptr`: clog2(DEPTH) bits, wrap modulo DEPTH.
- `count`: 0..DEPTH.
- `drop_cnt`: 0..FLUSH_DROP.
- `overflow`: 1 bit.

Handshake signals:
- push = `in_valid_i` & `in_ready_o` & (`drop_cnt`==0) & !`flush_i`.
- pop = `out_valid_o` & `out_ready_i` & !`flush_i`.

Combinational outputs:
- `in_ready_o` = (`count` != DEPTH) | (`drop_cnt` != 0). There is no pop-through when full: a beat offered while full is rejected even if a pop happens in the same cycle.
- `out_valid_o` = (`count` != 0).
- `out_pc_o` / `out_instr_o` = head entry while valid; forced to 0 while `out_valid_o`=0.
- `hold_o` = (`count` ≥ DEPTH−HOLD_MARGIN).
- `count_o` = `count`.

Push:
- The entry is written at `wr_ptr`, then `wr_ptr`++.

Pop:
- `rd_ptr`++.

Occupancy:
- push & pop: `count` unchanged.
- push only: `count`+1.
- pop only: `count`−1.

Drop window (`drop_cnt` ≠ 0 and no flush):
- Each `in_valid_i` beat is accepted (ready=1) and discarded; `drop_cnt`−1.
- Cycles with `in_valid_i`=0 do not decrement.

Overflow:
- `in_valid_i` & !`in_ready_o` & !`flush_i` sets `overflow`.
- The beat is lost.
- `overflow` is cleared only by reset.

Flush (highest priority after reset):
- Next cycle: `count`=0, `wr_ptr`=`rd_ptr`=0, `drop_cnt`=FLUSH_DROP.
- Any same-cycle push or pop is ignored; the consumer must not treat the head as consumed.
- The same-cycle `in_valid_i` beat is discarded and does not count against `drop_cnt`.
- A flush during a drop window reloads `drop_cnt`.
- Storage contents are not cleared.

Reset (asynchronous, may occur mid-operation):
- `count`=0, pointers 0, `drop_cnt`=0, `overflow`=0, storage 0.
- Outputs: `out_valid_o`=0, `out_pc_o`=0, `out_instr_o`=0, `count_o`=0, `overflow_o`=0, `hold_o`=0, `in_ready_o`=1.

## Timing
- Latency: a beat pushed in cycle N appears at the head in cycle N+1 if the queue was empty. There is no combinational bypass from in to out.
- Throughput: 1 push and 1 pop per cycle when 0 < `count` < DEPTH.
- `hold_o` follows the registered `count` (no combinational path from `in_valid_i`). With the default margin this leaves 2 slots for the PC-to-data in-flight beats after `hold_o` rises.
- `flush_i` to empty queue: 1 cycle. `out_valid_o`=0 in cycle N+1 even if a push was offered in cycle N.
- All state updates occur on `clk` rising edge, except reset.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `count`=3 → same-cycle asynchronous clear; `out_valid_o`=0, outputs 0, `in_ready_o`=1, `overflow_o`=0.
- **Fill:** push pc 0x0/0x4/0x8 (instr 0x13, 0x93, 0x113) with `out_ready_i`=0 → `count_o` steps 1,2,3; `hold_o` rises when `count_o`=2; head stays pc 0x0.
- **Overflow:** fill to 4 (pc 0x0..0xC), offer pc 0x10 → `in_ready_o`=0, `overflow_o`=1 sticky; drain yields 0x0, 0x4, 0x8, 0xC only, then `out_valid_o`=0.
- **Concurrent push/pop:** with `count`=2, push and pop in the same cycle → `count_o` stays 2, FIFO order preserved; from empty, push pc 0x20 → `out_valid_o` rises exactly 1 cycle later.
- **Flush:**
  - Stimulus: `count`=3, then `flush_i`=1 with pc 0x10 offered in the same cycle; next cycle pc 0x14 offered; then pc 0x40.
  - Required: `count_o`=0; pc 0x10 and pc 0x14 are both discarded; pc 0x40 is accepted and appears at the head 1 cycle later.
- **Flush inside drop window:** FLUSH_DROP=1, a second flush before any beat arrives → `drop_cnt` reloads; exactly one subsequent beat is dropped.
